// File: rtl/ucall_stack_pkg.sv
// Shared definitions for the microcode call/return stack: address width, default depth
// and the decoded stack operation.
package ucall_stack_pkg;

  localparam int unsigned UADDR_W      = 12;
  localparam int unsigned USTACK_DEPTH = 16;

  typedef logic [UADDR_W-1:0] uaddr_t;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_PUSH,
    OP_POP,
    OP_REPL
  } ustack_op_e;

  function automatic ustack_op_e decode_op(input logic call, input logic ret);
    case ({call, ret})
      2'b10:   return OP_PUSH;
      2'b01:   return OP_POP;
      2'b11:   return OP_REPL;
      default: return OP_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/ustack_ram.sv
// DEPTH x AW storage for the call stack: one synchronous write port and an asynchronous
// read port, sized to map onto distributed RAM.
module ustack_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 12,
  parameter int unsigned PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [PW-1:0] waddr_i,
  input  logic [AW-1:0] wdata_i,
  input  logic [PW-1:0] raddr_i,
  output logic [AW-1:0] rdata_o
);

  logic [AW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ucall_stack.sv
// Microcode call/return stack for the KS-10 microsequencer. Its top entry drives the
// RET dispatch source; every output is derived from registered state only.
module ucall_stack
  import ucall_stack_pkg::*;
#(
  parameter int unsigned DEPTH = USTACK_DEPTH,
  parameter int unsigned AW    = UADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clken,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] retADDR,
  output logic [AW-1:0] dispRET,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  output logic          unf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_MAX = (PW+1)'(DEPTH);

  logic [PW-1:0] sp_q, sp_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic          we;
  logic [PW-1:0] waddr;
  logic [PW-1:0] top_idx;
  logic [AW-1:0] top_data;
  logic          is_empty, is_full;
  ustack_op_e    op;

  assign top_idx  = sp_q - 1'b1;
  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == CNT_MAX);
  assign op       = decode_op(call, ret);

  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    we    = 1'b0;
    waddr = sp_q;
    if (clken) begin
      case (op)
        OP_PUSH: begin
          we   = 1'b1;
          sp_d = sp_q + 1'b1;
          if (is_full) ovf_d = 1'b1;
          else         cnt_d = cnt_q + 1'b1;
        end
        OP_POP: begin
          if (is_empty) begin
            unf_d = 1'b1;
          end else begin
            sp_d  = top_idx;
            cnt_d = cnt_q - 1'b1;
          end
        end
        OP_REPL: begin
          // Replacing the top of an empty stack degenerates to a plain push.
          we = 1'b1;
          if (is_empty) begin
            sp_d  = sp_q + 1'b1;
            cnt_d = cnt_q + 1'b1;
          end else begin
            waddr = top_idx;
          end
        end
        OP_HOLD: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  ustack_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .PW    (PW)
  ) u_ram (
    .clk     (clk),
    .we_i    (we & ~rst),
    .waddr_i (waddr),
    .wdata_i (retADDR),
    .raddr_i (top_idx),
    .rdata_o (top_data)
  );

  assign dispRET = is_empty ? '0 : top_data;
  assign empty   = is_empty;
  assign full    = is_full;
  assign ovf     = ovf_q;
  assign unf     = unf_q;

endmodule

// File: tb/tb_ucall_stack.sv
// Directed bench for ucall_stack: a vector table of single-edge operations with
// hand-computed results, plus explicit fill/overflow and RETURN-sampling sequences.
module tb_ucall_stack;

  logic        clk = 1'b0;
  logic        rst, clken, call, ret;
  logic [11:0] retADDR;
  logic [11:0] dispRET;
  logic        empty, full, ovf, unf;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  ucall_stack #(.DEPTH(16), .AW(12)) dut (
    .clk     (clk),
    .rst     (rst),
    .clken   (clken),
    .call    (call),
    .ret     (ret),
    .retADDR (retADDR),
    .dispRET (dispRET),
    .empty   (empty),
    .full    (full),
    .ovf     (ovf),
    .unf     (unf)
  );

  typedef struct {
    string       name;
    logic        rst, clken, call, ret;
    logic [11:0] addr;
    logic [11:0] disp;
    logic        e, f, o, u;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input logic r, input logic ce, input logic c,
                     input logic rt, input logic [11:0] a, input logic [11:0] d,
                     input logic e, input logic f, input logic o, input logic u);
    vec_t v;
    v.name = nm; v.rst = r; v.clken = ce; v.call = c; v.ret = rt; v.addr = a;
    v.disp = d; v.e = e; v.f = f; v.o = o; v.u = u;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got disp=%o e=%b f=%b ovf=%b unf=%b, want disp=%o e=%b f=%b ovf=%b unf=%b",
               nm, act[15:4], act[3], act[2], act[1], act[0],
               exp[15:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [15:0] outs();
    return {dispRET, empty, full, ovf, unf};
  endfunction

  task automatic drive(input logic r, input logic ce, input logic c, input logic rt,
                       input logic [11:0] a);
    rst = r; clken = ce; call = c; ret = rt; retADDR = a;
  endtask

  task automatic run_vec(input int unsigned i);
    drive(tbl[i].rst, tbl[i].clken, tbl[i].call, tbl[i].ret, tbl[i].addr);
    @(posedge clk); #1;
    check(tbl[i].name, outs(), {tbl[i].disp, tbl[i].e, tbl[i].f, tbl[i].o, tbl[i].u});
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 12'o0);

    //   name          rst ce call ret addr     disp     e f o u
    add("reset",       1, 0, 0, 0, 12'o0,    12'o0,    1,0,0,0);
    add("push1234",    0, 1, 1, 0, 12'o1234, 12'o1234, 0,0,0,0);
    add("pop1234",     0, 1, 0, 1, 12'o0,    12'o0,    1,0,0,0);
    add("push100",     0, 1, 1, 0, 12'o100,  12'o100,  0,0,0,0);
    add("push200",     0, 1, 1, 0, 12'o200,  12'o200,  0,0,0,0);
    add("push300",     0, 1, 1, 0, 12'o300,  12'o300,  0,0,0,0);
    add("idle",        0, 1, 0, 0, 12'o7,    12'o300,  0,0,0,0);
    add("pop300",      0, 1, 0, 1, 12'o0,    12'o200,  0,0,0,0);
    add("pop200",      0, 1, 0, 1, 12'o0,    12'o100,  0,0,0,0);
    add("pop100",      0, 1, 0, 1, 12'o0,    12'o0,    1,0,0,0);
    add("pop_empty",   0, 1, 0, 1, 12'o0,    12'o0,    1,0,0,1);
    add("repl_empty",  0, 1, 1, 1, 12'o777,  12'o777,  0,0,0,1);
    add("pop777",      0, 1, 0, 1, 12'o0,    12'o0,    1,0,0,1);
    add("reset2",      1, 1, 1, 1, 12'o3,    12'o0,    1,0,0,0);
    add("push5",       0, 1, 1, 0, 12'o5,    12'o5,    0,0,0,0);
    add("repl42",      0, 1, 1, 1, 12'o42,   12'o42,   0,0,0,0);
    add("pop42",       0, 1, 0, 1, 12'o0,    12'o0,    1,0,0,0);
    // index 17.. : run after the overflow sequence (ovf=1, unf=1 at that point)
    add("clken0_a",    0, 0, 1, 0, 12'o55,   12'o0,    1,0,1,1);
    add("clken0_b",    0, 0, 1, 0, 12'o55,   12'o0,    1,0,1,1);
    add("clken0_c",    0, 0, 0, 1, 12'o55,   12'o0,    1,0,1,1);
    add("clken0_d",    0, 0, 1, 1, 12'o55,   12'o0,    1,0,1,1);
    add("push11",      0, 1, 1, 0, 12'o11,   12'o11,   0,0,1,1);
    add("rst_call",    1, 1, 1, 0, 12'o55,   12'o0,    1,0,0,0);
    add("post_rst",    0, 1, 0, 0, 12'o55,   12'o0,    1,0,0,0);
    add("push66",      0, 1, 1, 0, 12'o66,   12'o66,   0,0,0,0);

    for (int unsigned i = 0; i < 17; i++) run_vec(i);

    // Fill beyond DEPTH: value 1 is overwritten by 17.
    for (int unsigned k = 1; k <= 17; k++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 12'(k));
      @(posedge clk); #1;
      check($sformatf("fill%0d", k), outs(),
            {12'(k), 1'b0, (k >= 16) ? 1'b1 : 1'b0, (k == 17) ? 1'b1 : 1'b0, 1'b0});
    end
    // Drain: top is visible combinationally while ret is asserted, before the pop edge.
    for (int unsigned k = 0; k < 16; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 12'o0);
      #1;
      check($sformatf("ret_sample%0d", k), outs(),
            {12'(17 - k), 1'b0, (k == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0});
      @(posedge clk); #1;
      check($sformatf("drain%0d", k), outs(),
            {(k < 15) ? 12'(16 - k) : 12'o0, (k == 15) ? 1'b1 : 1'b0, 1'b0, 1'b1, 1'b0});
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 12'o0);
    @(posedge clk); #1;
    check("pop_after_drain", outs(), {12'o0, 1'b1, 1'b0, 1'b1, 1'b1});

    for (int unsigned i = 17; i < tbl.size(); i++) run_vec(i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
